// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and defaults for the memory port arbiter
package mips_mem_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MEM_LAT = 1;
    // Wide enough for the largest supported latency (4).
    localparam int LAT_W       = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// rtl/mem_lat_counter.sv - read latency down-counter with a last-cycle flag
module mem_lat_counter
    import mips_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [LAT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // A value of one marks the cycle in which the memory data is valid.
    assign done = (count == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-port memory
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LAT      = DEF_MEM_LAT,
    parameter int MAX_DM_BURST = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int STREAK_W = (MAX_DM_BURST < 1) ? 1 : $clog2(MAX_DM_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_BURST);
    localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT);

    arb_state_t          state;
    logic [STREAK_W-1:0] dm_streak;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   dm_rdata_q;
    logic                lat_done;
    logic                busy_done;
    logic                can_grant;
    logic                if_wins;
    logic                rd_grant;

    mem_lat_counter u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (rd_grant),
        .load_val (LAT_LOAD),
        .dec      (state != IDLE),
        .done     (lat_done)
    );

    // The completion cycle of a read doubles as a grant slot.
    assign busy_done = (state != IDLE) && lat_done;
    assign can_grant = !rst && ((state == IDLE) || busy_done);

    // Data side has priority until the fetch side has waited out a full burst.
    assign if_wins  = if_req && (!dm_req || (dm_streak == STREAK_MAX));
    assign if_gnt   = can_grant && if_wins;
    assign dm_gnt   = can_grant && dm_req && !if_wins;
    assign rd_grant = if_gnt || (dm_gnt && !dm_we);

    assign if_rvalid = !rst && (state == BUSY_IF) && lat_done;
    assign dm_rvalid = !rst && (state == BUSY_DM) && lat_done;
    assign if_rdata  = rst ? '0 : (if_rvalid ? mem_rdata : if_rdata_q);
    assign dm_rdata  = rst ? '0 : (dm_rvalid ? mem_rdata : dm_rdata_q);

    assign mem_en    = if_gnt || dm_gnt;
    assign mem_we    = dm_gnt && dm_we;
    assign mem_addr  = dm_gnt ? dm_addr : (if_gnt ? if_addr : '0);
    assign mem_wdata = dm_gnt ? dm_wdata : '0;

    assign stall_if  = !rst && ((if_req && !if_gnt) || ((state == BUSY_IF) && !if_rvalid));
    assign stall_mem = !rst && ((dm_req && !dm_gnt) || ((state == BUSY_DM) && !dm_rvalid));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dm_streak  <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (if_gnt) begin
                state <= BUSY_IF;
            end else if (dm_gnt && !dm_we) begin
                state <= BUSY_DM;
            end else if (busy_done) begin
                state <= IDLE;
            end

            if (!if_req || if_gnt) begin
                dm_streak <= '0;
            end else if (dm_gnt && (dm_streak != STREAK_MAX)) begin
                dm_streak <= dm_streak + 1'b1;
            end

            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (dm_rvalid) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

endmodule
